// File: rtl/gmul_sc_pkg.sv
// Shared types and constants for the stochastic-computing multiplier.
package gmul_sc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} gmul_state_t;

  localparam logic MODE_UNI = 1'b0;
  localparam logic MODE_BI  = 1'b1;

endpackage

// File: rtl/gmul_sc_acc_cmp_gen.sv
// Operand register plus strict unsigned compare against a random sequence; compare is combinational.
// No backpressure: the operand is loaded whenever load is high.
module sc_cmp_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] op,
  input  logic [WIDTH-1:0] seq,
  output logic             gt
);

  logic [WIDTH-1:0] op_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_buf <= '0;
    end else if (load) begin
      op_buf <= op;
    end
  end

  assign gt = op_buf > seq;

endmodule

// File: rtl/gmul_sc_acc.sv
// Stochastic multiplier: N=2^LEN_LOG2 product bits counted into result; done N+1 cycles after start.
// No backpressure: start is ignored while busy, clear aborts to IDLE at any time.
module gmul_sc_acc
  import gmul_sc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LEN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                clear,
  input  logic                mode,
  input  logic [WIDTH-1:0]    iA,
  input  logic [WIDTH-1:0]    iB,
  input  logic [WIDTH-1:0]    sobolSeqA,
  input  logic [WIDTH-1:0]    sobolSeqB,
  output logic                seq_en,
  output logic                busy,
  output logic                oC,
  output logic                oC_valid,
  output logic                done,
  output logic [LEN_LOG2:0]   result
);

  gmul_state_t         state, state_nxt;
  logic [LEN_LOG2-1:0] cnt;
  logic [LEN_LOG2:0]   acc;
  logic                mode_buf;
  logic                gt_a, gt_b, prod;
  logic                load, in_run, step, last;

  assign in_run = (state == RUN);
  assign load   = start && !clear && (state != RUN);
  assign step   = in_run && !clear;
  assign last   = step && (cnt == '1);

  sc_cmp_gen #(.WIDTH(WIDTH)) u_cmp_a (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .op   (iA),
    .seq  (sobolSeqA),
    .gt   (gt_a)
  );

  sc_cmp_gen #(.WIDTH(WIDTH)) u_cmp_b (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .op   (iB),
    .seq  (sobolSeqB),
    .gt   (gt_b)
  );

  assign prod = (mode_buf == MODE_BI) ? ~(gt_a ^ gt_b) : (gt_a & gt_b);

  always_comb begin
    state_nxt = state;
    seq_en    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        seq_en = 1'b1;
        busy   = 1'b1;
        if (cnt == '1) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_buf <= MODE_UNI;
      cnt      <= '0;
      acc      <= '0;
      oC       <= 1'b0;
      oC_valid <= 1'b0;
      result   <= '0;
    end else begin
      state    <= state_nxt;
      oC_valid <= step;
      if (load) begin
        mode_buf <= mode;
        cnt      <= '0;
        acc      <= '0;
      end else if (step) begin
        cnt <= cnt + LEN_LOG2'(1);
        acc <= acc + (LEN_LOG2+1)'(prod);
      end
      if (step) oC <= prod;
      // Final bit is folded in here since acc only sees it at the next edge.
      if (last) result <= acc + (LEN_LOG2+1)'(prod);
    end
  end

endmodule

// File: doc/gmul_sc_acc.md
Name: gmul_sc_acc

Overview:
- Parametrised stochastic-computing multiplier that runs for a fixed stream length and produces a binary result.
- On a start request it latches two WIDTH-bit operands and a mode bit.
- It then runs exactly 2^LEN_LOG2 cycles, generating one product bit per cycle in either unipolar (AND) or bipolar (XNOR) encoding.
- It counts the product bitstream into a binary result and signals completion with a one-cycle done pulse.
- It sits between the shared Sobol RNG (driven through seq_en) and the MAC accumulation stage.

Parameters:
- WIDTH, 8, operand and Sobol sequence width.
- LEN_LOG2, 8, log2 of bitstream length N = 2^LEN_LOG2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request to latch operands and begin a run.
- clear  input  1  synchronous abort; returns the block to IDLE.
- mode  input  1  0 = unipolar (AND), 1 = bipolar (XNOR); latched on an accepted start.
- iA  input  WIDTH  operand A; latched on an accepted start.
- iB  input  WIDTH  operand B; latched on an accepted start.
- sobolSeqA  input  WIDTH  random sequence for A; sampled in RUN cycles.
- sobolSeqB  input  WIDTH  random sequence for B; sampled in RUN cycles.
- seq_en  output  1  high in RUN; the RNG advances one step per cycle while it is high.
- busy  output  1  high in RUN.
- oC  output  1  registered product bit.
- oC_valid  output  1  qualifies oC.
- done  output  1  one-cycle completion pulse.
- result  output  LEN_LOG2+1  count of ones in the last completed stream.

Behaviour:
- Reset: the following are all 0, and state is IDLE.
  - Outputs: seq_en, busy, oC, oC_valid, done, result.
  - Internal: operand buffers, mode buffer, cycle counter, accumulator.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at cycle t latches iA, iB and mode, clears the counter and the accumulator, and moves to RUN.
- RUN:
  - Occupies cycles t+1 .. t+N.
  - Per cycle: a = (bufA > sobolSeqA), b = (bufB > sobolSeqB). Both comparisons are strict and unsigned.
  - bit = mode ? ~(a^b) : (a&b).
  - At the next edge: oC <= bit, oC_valid <= 1, accumulator += bit, counter += 1.
  - When counter = N-1: result <= accumulator + bit, and the state moves to DONE.
- Output timing:
  - oC_valid is high for cycles t+2 .. t+N+1, exactly N cycles.
  - done is high only in cycle t+N+1, which is the DONE state.
- DONE:
  - Lasts one cycle, then the state returns to IDLE.
  - start in DONE is accepted exactly as in IDLE; the next RUN begins in the following cycle.
  - Back-to-back runs therefore have a one-cycle gap.
- start in RUN is ignored; busy indicates this condition.
- Operand and mode inputs are don't-care except in the cycle where a start is accepted.
- result is held from done until the next done. A new start does not change result.
- Width rules:
  - result is LEN_LOG2+1 bits so that the full count N is representable.
  - The accumulator has the same width and cannot overflow.
- clear:
  - Highest priority, over both start and the RUN transitions.
  - In any state, clear forces IDLE at the next edge and zeroes seq_en, busy, oC_valid and done.
  - result keeps its previous value.
- Asynchronous reset mid-run: all state and outputs return to 0 immediately.

Decomposition:
- Package gmul_sc_pkg contains:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} gmul_state_t;
  - mode constants MODE_UNI = 1'b0 and MODE_BI = 1'b1.
- Sub-module sc_cmp_gen (parameter WIDTH):
  - A WIDTH-bit operand register with a load enable.
  - A combinational strict comparator against the sequence input.
  - Instantiated twice, once for A and once for B.
- The top level holds the FSM, counter, accumulator and output registers.

Test Plan:
Common setup: WIDTH=8, LEN_LOG2=8. Unless stated, both Sobol inputs are driven with a counter 0..255 that advances on seq_en.
1. Unipolar, iA=128, iB=255, sobolSeqB held at 0 -> result=128; done pulses at start+257; oC_valid high for exactly 256 cycles.
2. Unipolar, iA=255, iB=255 -> result=255. Then a second start in the DONE cycle with iA=0 -> result stays 255 during the run, becomes 0 at the second done, and no extra idle cycle is inserted.
3. Bipolar, iA=iB=77 -> all bits 1, result=256 (full 9-bit boundary). Bipolar, iA=0, iB=255 -> result=1.
4. start pulsed at run cycles 10 and 100, with operand inputs changed each time -> ignored; result=128, matching scenario 1.
5. clear at RUN cycle 50 -> IDLE next cycle; busy, seq_en and oC_valid drop to 0; done is never asserted; result keeps its prior value. A fresh start then completes normally.
6. rst_n asserted mid-run, asynchronously between edges -> all outputs 0 immediately. After release, start with iA=64, iB=255, sobolSeqB held at 0 -> result=64.
